// File: rtl/mmap_pkg.sv
// Shared constants and types for the memory-map router: default CPU map,
// region index sizing, and the tag carried down the read-response pipe.
package mmap_pkg;

  localparam int MMAP_MAX_REGIONS = 8;

  function automatic int idxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idxW(MMAP_MAX_REGIONS);

  localparam logic [15:0] DMEM_BASE  = 16'h0000;
  localparam logic [15:0] DMEM_LIMIT = 16'h07FF;
  localparam logic [15:0] IO_BASE    = 16'h1000;
  localparam logic [15:0] IO_LIMIT   = 16'h10FF;
  localparam logic [15:0] VMEM_BASE  = 16'h2000;
  localparam logic [15:0] VMEM_LIMIT = 16'h2960;

  // Wide enough for any supported DATA_W; callers slice the low bits.
  localparam logic [63:0] RD_DATA_ABORT = '1;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             mapped;
    logic             abort;
  } rdTag_t;

endpackage

// File: rtl/mmap_rd_pipe.sv
// Fixed-latency shift pipe tracking outstanding reads; advances every cycle
// so responses line up with the slaves' synchronous read latency.
module mmap_rd_pipe
  import mmap_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  rdTag_t push,
  output rdTag_t tail
);

  rdTag_t [RD_LATENCY-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= push;
      for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[RD_LATENCY-1];

endmodule

// File: rtl/mmap_router.sv
// CPU-to-slave memory-map router with back-pressure and sticky error capture.
// Optional: define MMAP_TIMEOUT_EN to abort accesses stalled for WAIT_TIMEOUT cycles.
module mmap_router
  import mmap_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int RD_LATENCY  = 1,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = {16'h3000, VMEM_BASE, IO_BASE, DMEM_BASE},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = {16'h30FF, VMEM_LIMIT, IO_LIMIT, DMEM_LIMIT},
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_W-1:0]             m_addr,
  input  logic [DATA_W-1:0]             m_wdata,
  input  logic                          m_we,
  input  logic                          m_re,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_stall,
  output logic                          m_err,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [NUM_REGIONS-1:0]        s_we,
  output logic [NUM_REGIONS-1:0]        s_re,
  input  logic [NUM_REGIONS*DATA_W-1:0] s_rdata,
  input  logic [NUM_REGIONS-1:0]        s_ready,
  output logic                          err_valid,
  output logic [ADDR_W-1:0]             err_addr,
  input  logic                          err_clr
);

  if (NUM_REGIONS < 1 || NUM_REGIONS > MMAP_MAX_REGIONS) begin : gBadRegions
    $error("mmap_router: NUM_REGIONS out of range");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : gBadLatency
    $error("mmap_router: RD_LATENCY out of range");
  end
  if (WAIT_TIMEOUT < 1) begin : gBadTimeout
    $error("mmap_router: WAIT_TIMEOUT must be positive");
  end

  logic [NUM_REGIONS-1:0] hit, sel;
  logic [IDX_W-1:0]       idx;
  logic                   mapped, req, rdReq, ready, stallRaw, abort, errNow;
  logic [DATA_W-1:0]      rdSel;
  rdTag_t                 push, tail;

  // Scan high-to-low so the lowest matching region index wins overlaps.
  always_comb begin
    hit = '0;
    idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      hit[i] = (m_addr >= REGION_BASE[i*ADDR_W +: ADDR_W]) &&
               (m_addr <= REGION_LIMIT[i*ADDR_W +: ADDR_W]);
      if (hit[i]) idx = IDX_W'(i);
    end
  end

  assign mapped   = |hit;
  assign sel      = mapped ? (NUM_REGIONS'(1) << idx) : '0;
  assign req      = m_we | m_re;
  assign rdReq    = m_re & ~m_we;
  assign ready    = |(sel & s_ready);
  assign stallRaw = req & mapped & ~ready;

`ifdef MMAP_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_TIMEOUT + 1);
  logic [CW-1:0] stallCnt;

  assign abort = stallRaw & (stallCnt == CW'(WAIT_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               stallCnt <= '0;
    else if (stallRaw & ~abort) stallCnt <= stallCnt + 1'b1;
    else                      stallCnt <= '0;
  end
`else
  assign abort = 1'b0;
`endif

  assign m_stall = stallRaw & ~abort;
  assign s_addr  = m_addr;
  assign s_wdata = m_wdata;
  // Enables fire only on the accept cycle; an aborted access also has stallRaw set.
  assign s_we    = (m_we  & ~stallRaw) ? sel : '0;
  assign s_re    = (rdReq & ~stallRaw) ? sel : '0;
  assign errNow  = (req & ~mapped) | abort;

  always_comb begin
    push        = '0;
    push.valid  = rdReq & (~stallRaw | abort);
    push.idx    = idx;
    push.mapped = mapped & ~abort;
    push.abort  = abort;
  end

  mmap_rd_pipe #(.RD_LATENCY(RD_LATENCY)) uRdPipe (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .tail  (tail)
  );

  always_comb begin
    rdSel = '0;
    for (int i = 0; i < NUM_REGIONS; i++)
      if (tail.idx == IDX_W'(i)) rdSel = s_rdata[i*DATA_W +: DATA_W];
    m_rdata = '0;
    if (tail.valid) begin
      if (tail.abort)       m_rdata = RD_DATA_ABORT[DATA_W-1:0];
      else if (tail.mapped) m_rdata = rdSel;
    end
  end

  // A new error wins over a simultaneous clear so it is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_err     <= 1'b0;
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else begin
      m_err <= errNow;
      if (errNow & (~err_valid | err_clr)) begin
        err_valid <= 1'b1;
        err_addr  <= m_addr;
      end else if (err_clr) begin
        err_valid <= 1'b0;
        err_addr  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mmap_router.sv
// Self-checking bench for mmap_router: directed map cases plus random traffic
// against a transaction-level model (address map table, reference memory, response queue).
module tb_mmap_router;

  localparam int NR = 4;
  localparam int LAT = 1;
  localparam int TMO = 15;

  logic        clk, rst_n;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;
  logic        m_we, m_re, m_stall, m_err;
  logic [15:0] s_addr;
  logic [7:0]  s_wdata;
  logic [NR-1:0] s_we, s_re, s_ready;
  logic [NR*8-1:0] s_rdata;
  logic        err_valid, err_clr;
  logic [15:0] err_addr;

  mmap_router dut (
    .clk(clk), .rst_n(rst_n), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
    .m_re(m_re), .m_rdata(m_rdata), .m_stall(m_stall), .m_err(m_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_re(s_re),
    .s_rdata(s_rdata), .s_ready(s_ready), .err_valid(err_valid),
    .err_addr(err_addr), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave RAMs, one-cycle synchronous read, keyed by region and address.
  logic [7:0] smem [int];
  logic [7:0] srd [NR];
  always @(posedge clk) begin
    for (int r = 0; r < NR; r++) begin
      if (s_re[r]) srd[r] <= smem.exists(r*65536 + int'(s_addr)) ? smem[r*65536 + int'(s_addr)] : 8'h00;
      if (s_we[r]) smem[r*65536 + int'(s_addr)] = s_wdata;
    end
  end
  always_comb for (int r = 0; r < NR; r++) s_rdata[r*8 +: 8] = srd[r];

  // Reference model state.
  int unsigned mBase [NR] = '{32'h0000, 32'h1000, 32'h2000, 32'h3000};
  int unsigned mLim  [NR] = '{32'h07FF, 32'h10FF, 32'h2960, 32'h30FF};
  logic [7:0] refMem [int];
  typedef struct { int due; logic [7:0] data; } rsp_t;
  rsp_t expQ [$];
  int cyc, stallCnt;
  logic errPend, errValidM;
  logic [15:0] errAddrM;
  int nChk, nFail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int decode(input logic [15:0] a);
    for (int i = 0; i < NR; i++)
      if (int'(a) >= mBase[i] && int'(a) <= mLim[i]) return i;
    return -1;
  endfunction

  task automatic modelReset();
    expQ.delete();
    errPend = 0; errValidM = 0; errAddrM = '0; stallCnt = 0;
  endtask

  // One CPU cycle: drive at negedge, check everything in the low phase, update model.
  task automatic step(input logic [15:0] a, input logic we, input logic re,
                      input logic [7:0] wd, input logic [3:0] rdy, input logic clr);
    int r;
    logic stall, abrt, newErr, rdAcc;
    logic [3:0] expSel;
    logic [7:0] expRd, rdVal;
    @(negedge clk);
    m_addr = a; m_we = we; m_re = re; m_wdata = wd; s_ready = rdy; err_clr = clr;
    #1;
    r = decode(a);
    stall = (we | re) && r >= 0 && !rdy[r];
    abrt = 1'b0;
`ifdef MMAP_TIMEOUT_EN
    abrt = stall && stallCnt == TMO;
    stallCnt = (stall && !abrt) ? stallCnt + 1 : 0;
`endif
    expSel = (r >= 0) ? 4'(1 << r) : 4'b0;
    chk("m_stall", m_stall, stall && !abrt);
    chk("s_we", s_we, (we && !stall) ? expSel : 4'b0);
    chk("s_re", s_re, (re && !we && !stall) ? expSel : 4'b0);
    chk("s_addr", s_addr, a);
    expRd = 8'h00;
    if (expQ.size() > 0 && expQ[0].due == cyc) expRd = expQ.pop_front().data;
    chk("m_rdata", m_rdata, expRd);
    chk("m_err", m_err, errPend);
    chk("err_valid", err_valid, errValidM);
    chk("err_addr", err_addr, errAddrM);
    if (we && r >= 0 && !stall) refMem[int'(a)] = wd;
    rdAcc = re && !we && (!stall || abrt);
    if (rdAcc) begin
      if (abrt)        rdVal = 8'hFF;
      else if (r < 0)  rdVal = 8'h00;
      else             rdVal = refMem.exists(int'(a)) ? refMem[int'(a)] : 8'h00;
      expQ.push_back('{cyc + LAT, rdVal});
    end
    newErr = ((we | re) && r < 0) || abrt;
    if (newErr && (!errValidM || clr)) begin errValidM = 1; errAddrM = a; end
    else if (clr) begin errValidM = 0; errAddrM = '0; end
    errPend = newErr;
    cyc++;
  endtask

  task automatic idle(); step(16'h0000, 0, 0, 8'h00, 4'hF, 0); endtask

  task automatic resetMid();
    @(posedge clk); #1;
    m_we = 0; m_re = 0; err_clr = 0; s_ready = 4'hF;
    rst_n = 1'b0;
    #1;
    chk("rst m_rdata", m_rdata, 8'h00);
    chk("rst m_err", m_err, 1'b0);
    chk("rst err_valid", err_valid, 1'b0);
    chk("rst err_addr", err_addr, 16'h0000);
    chk("rst s_re", s_re, 4'b0);
    chk("rst s_we", s_we, 4'b0);
    modelReset();
    @(negedge clk); rst_n = 1'b1;
  endtask

  logic [15:0] pick [10] = '{16'h0000, 16'h07FF, 16'h0800, 16'h0FFF, 16'h1000,
                             16'h10FF, 16'h2000, 16'h2960, 16'h2961, 16'h30FF};

  initial begin
    nChk = 0; nFail = 0; cyc = 0;
    modelReset();
    m_addr = '0; m_wdata = '0; m_we = 0; m_re = 0; s_ready = 4'hF; err_clr = 0;
    rst_n = 1'b0;
    #12;
    chk("reset m_rdata", m_rdata, 8'h00);
    chk("reset m_stall", m_stall, 1'b0);
    chk("reset m_err", m_err, 1'b0);
    chk("reset err_valid", err_valid, 1'b0);
    chk("reset err_addr", err_addr, 16'h0000);
    chk("reset s_we", s_we, 4'b0);
    chk("reset s_re", s_re, 4'b0);
    @(negedge clk); rst_n = 1'b1;

    // Basic write/read in DMEM.
    step(16'h0010, 1, 0, 8'h5A, 4'hF, 0);
    step(16'h0010, 0, 1, 8'h00, 4'hF, 0);
    idle();
    // Region boundaries, back-to-back reads.
    step(16'h07FF, 1, 0, 8'h11, 4'hF, 0);
    step(16'h1000, 1, 0, 8'h22, 4'hF, 0);
    step(16'h2960, 1, 0, 8'h33, 4'hF, 0);
    step(16'h07FF, 0, 1, 8'h00, 4'hF, 0);
    step(16'h1000, 0, 1, 8'h00, 4'hF, 0);
    step(16'h2960, 0, 1, 8'h00, 4'hF, 0);
    idle();
    // Unmapped reads; first error address sticks.
    step(16'h0800, 0, 1, 8'h00, 4'hF, 0);
    idle();
    step(16'h4000, 0, 1, 8'h00, 4'hF, 0);
    idle(); idle();
    // Stalled write to IO.
    repeat (3) step(16'h1004, 1, 0, 8'h77, 4'b1101, 0);
    step(16'h1004, 1, 0, 8'h77, 4'hF, 0);
    step(16'h1004, 0, 1, 8'h00, 4'hF, 0);
    idle();
    // Clear coinciding with a new error, then a plain clear.
    step(16'h3100, 0, 1, 8'h00, 4'hF, 1);
    idle();
    step(16'h0000, 0, 0, 8'h00, 4'hF, 1);
    idle();
    // Write and read together: write only.
    step(16'h0020, 1, 1, 8'hC3, 4'hF, 0);
    step(16'h0020, 0, 1, 8'h00, 4'hF, 0);
    idle();
`ifdef MMAP_TIMEOUT_EN
    repeat (TMO + 1) step(16'h2000, 0, 1, 8'h00, 4'b1011, 0);
    idle(); idle();
`endif
    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      logic [3:0] rdy;
      case ($urandom_range(0, 2))
        0: a = pick[$urandom_range(0, 9)];
        1: a = 16'($urandom);
        default: a = 16'(mBase[$urandom_range(0, NR-1)] + $urandom_range(0, 31));
      endcase
      for (int b = 0; b < NR; b++) rdy[b] = ($urandom_range(0, 7) != 0);
      step(a, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           8'($urandom), rdy, $urandom_range(0, 15) == 0);
    end
    idle(); idle();
    // Reset with a read in flight.
    step(16'h0010, 0, 1, 8'h00, 4'hF, 0);
    resetMid();
    idle();
    step(16'h0010, 0, 1, 8'h00, 4'hF, 0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
